// File: rtl/mem_responder.sv
// Memory-side responder: req/ack handshake with programmable wait states,
// byte-lane merging for sub-word stores, and misalignment / range error flagging.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        addr_err,
    output logic        busy
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        err_q;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero latency the commit edge is the acceptance edge, so the
    // operation must come straight from the inputs while still in IDLE.
    logic        op_wr;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;

    assign op_wr    = (state == IDLE) ? wr    : wr_q;
    assign op_size  = (state == IDLE) ? size  : size_q;
    assign op_addr  = (state == IDLE) ? addr  : addr_q;
    assign op_wdata = (state == IDLE) ? wdata : wdata_q;

    logic          commit;
    logic          op_err;
    logic [AW-1:0] idx;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic [31:0]   word_rd, word_sh, load_val;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req) begin
                state_nx = (LATENCY == 0) ? RESP : WAIT;
                cnt_nx   = CNT_INIT;
            end
            WAIT: if (cnt == 4'd0) state_nx = RESP;
                  else             cnt_nx   = cnt - 4'd1;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign commit = (state_nx == RESP) && (state != RESP);

    assign op_err = (op_size == 2'b11)
                 || (op_size == 2'b00 && op_addr[1:0] != 2'b00)
                 || (op_size == 2'b01 && op_addr[0])
                 || (op_addr >= LIMIT);

    assign idx     = op_addr[AW+1:2];
    assign word_rd = mem[idx];
    assign word_sh = word_rd >> {op_addr[1:0], 3'b000};

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = op_wdata;
        load_val  = word_rd;
        case (op_size)
            2'b00: begin
                lane_en   = 4'b1111;
                lane_data = op_wdata;
                load_val  = word_rd;
            end
            2'b01: begin
                lane_en   = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{op_wdata[15:0]}};
                load_val  = {16'h0000, word_sh[15:0]};
            end
            2'b10: begin
                lane_en   = 4'b0001 << op_addr[1:0];
                lane_data = {4{op_wdata[7:0]}};
                load_val  = {24'h000000, word_sh[7:0]};
            end
            default: begin
                lane_en   = 4'b0000;
                lane_data = op_wdata;
                load_val  = word_rd;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'h0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (commit) begin
                err_q <= op_err;
                if (!op_err && !op_wr) rdata <= load_val;
            end
        end
    end

    // NOTE: the request latch and the array carry no reset; they are always written before use, and a reset port on a RAM would block RAM inference.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && commit && op_wr && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign ack      = (state == RESP);
    assign addr_err = ack && err_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=2, DEPTH_WORDS=256; expected
// values are hand-computed constants.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack, addr_err, busy;

    int tests = 0;
    int fails = 0;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
        .addr_err(addr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives one request, drops req after acceptance, and reports how many
    // negedges after the acceptance edge ack was first seen (0 = timeout).
    task automatic run_txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic err,
                           output logic [31:0] rd);
        lat = 0; err = 1'b0; rd = 32'h0;
        @(negedge clk);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; wr = ~w;
            if (ack) begin
                lat = n; err = addr_err; rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", ack); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", addr_err); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        reset = 1'b1;
    endtask

    task automatic test_word;
        int lat; logic err; logic [31:0] rd;
        run_txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, lat, err, rd);
        tests++; if (lat !== LAT + 1) begin fails++; $display("FAIL st_word_lat got=%0d exp=%0d", lat, LAT + 1); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL st_word_err got=%b exp=0", err); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL st_word_rdata got=%h exp=0", rd); end
        run_txn(1'b0, 2'b00, 32'h10, 32'h0, lat, err, rd);
        tests++; if (lat !== LAT + 1) begin fails++; $display("FAIL ld_word_lat got=%0d exp=%0d", lat, LAT + 1); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ld_word_err got=%b exp=0", err); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL ld_word_rdata got=%h exp=deadbeef", rd); end
        @(negedge clk);
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL err_outside_ack got=%b exp=0", addr_err); end
    endtask

    task automatic test_lanes;
        int lat; logic err; logic [31:0] rd;
        run_txn(1'b1, 2'b00, 32'h10, 32'h11223344, lat, err, rd);
        run_txn(1'b1, 2'b10, 32'h11, 32'h555555AA, lat, err, rd);
        run_txn(1'b0, 2'b00, 32'h10, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h1122AA44) begin fails++; $display("FAIL byte_merge got=%h exp=1122aa44", rd); end
        run_txn(1'b0, 2'b10, 32'h11, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h000000AA) begin fails++; $display("FAIL ld_byte got=%h exp=000000aa", rd); end
        run_txn(1'b0, 2'b10, 32'h13, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h00000011) begin fails++; $display("FAIL ld_byte3 got=%h exp=00000011", rd); end
        run_txn(1'b1, 2'b01, 32'h12, 32'hFFFF7788, lat, err, rd);
        run_txn(1'b0, 2'b00, 32'h10, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h7788AA44) begin fails++; $display("FAIL half_merge got=%h exp=7788aa44", rd); end
        run_txn(1'b1, 2'b00, 32'h10, 32'h80FF0000, lat, err, rd);
        run_txn(1'b0, 2'b01, 32'h12, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h000080FF) begin fails++; $display("FAIL ld_half got=%h exp=000080ff", rd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ld_half_err got=%b exp=0", err); end
        run_txn(1'b0, 2'b01, 32'h13, 32'h0, lat, err, rd);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL ld_half_misalign_err got=%b exp=1", err); end
        tests++; if (rd !== 32'h000080FF) begin fails++; $display("FAIL ld_half_misalign_rdata got=%h exp=000080ff", rd); end
        run_txn(1'b1, 2'b01, 32'h13, 32'h00001234, lat, err, rd);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL st_half_misalign_err got=%b exp=1", err); end
        run_txn(1'b1, 2'b00, 32'h12, 32'h01010101, lat, err, rd);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL st_word_misalign_err got=%b exp=1", err); end
        run_txn(1'b0, 2'b00, 32'h10, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h80FF0000) begin fails++; $display("FAIL misalign_no_write got=%h exp=80ff0000", rd); end
    endtask

    task automatic test_range;
        int lat; logic err; logic [31:0] rd;
        run_txn(1'b1, 2'b00, 32'h0, 32'h01020304, lat, err, rd);
        run_txn(1'b1, 2'b00, 32'h400, 32'hFFFFFFFF, lat, err, rd);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL st_oor_err got=%b exp=1", err); end
        tests++; if (lat !== LAT + 1) begin fails++; $display("FAIL st_oor_lat got=%0d exp=%0d", lat, LAT + 1); end
        run_txn(1'b1, 2'b00, 32'h1000_0000, 32'hEEEEEEEE, lat, err, rd);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL st_high_err got=%b exp=1", err); end
        run_txn(1'b0, 2'b00, 32'h0, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h01020304) begin fails++; $display("FAIL no_wrap got=%h exp=01020304", rd); end
        run_txn(1'b1, 2'b00, 32'h3FC, 32'hCAFEF00D, lat, err, rd);
        run_txn(1'b0, 2'b00, 32'h3FC, 32'h0, lat, err, rd);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ld_last_err got=%b exp=0", err); end
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL ld_last got=%h exp=cafef00d", rd); end
        run_txn(1'b0, 2'b11, 32'h0, 32'h0, lat, err, rd);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL size11_err got=%b exp=1", err); end
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL size11_rdata got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_back_to_back;
        int acks;
        int first;
        int second;
        logic idle_seen;
        acks = 0; first = 0; second = 0; idle_seen = 1'b0;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h10;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 5) req = 1'b0;
            if (n == 4 && !busy) idle_seen = 1'b1;
            if (ack) begin
                acks++;
                if (acks == 1) first = n; else second = n;
            end
        end
        tests++; if (first !== 3) begin fails++; $display("FAIL b2b_first got=%0d exp=3", first); end
        tests++; if (second !== 7) begin fails++; $display("FAIL b2b_second got=%0d exp=7", second); end
        tests++; if (acks !== 2) begin fails++; $display("FAIL b2b_acks got=%0d exp=2", acks); end
        tests++; if (idle_seen !== 1'b1) begin fails++; $display("FAIL b2b_idle_gap got=%b exp=1", idle_seen); end

        acks = 0;
        @(negedge clk);
        req = 1'b1; addr = 32'h10;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            req = (n == 1 || n == 3);
            if (ack) acks++;
        end
        req = 1'b0;
        tests++; if (acks !== 1) begin fails++; $display("FAIL ignore_pulse_acks got=%0d exp=1", acks); end
    endtask

    task automatic test_reset_abort;
        int lat; logic err; logic [31:0] rd;
        int acks;
        acks = 0;
        run_txn(1'b1, 2'b00, 32'h20, 32'h5A5A5A5A, lat, err, rd);
        run_txn(1'b0, 2'b00, 32'h20, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h5A5A5A5A) begin fails++; $display("FAIL abort_pre got=%h exp=5a5a5a5a", rd); end
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL abort_rdata got=%h exp=0", rdata); end
        for (int n = 0; n < 6; n++) begin
            if (ack) acks++;
            @(negedge clk);
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL abort_acks got=%0d exp=0", acks); end
        run_txn(1'b0, 2'b00, 32'h20, 32'h0, lat, err, rd);
        tests++; if (rd !== 32'h5A5A5A5A) begin fails++; $display("FAIL abort_no_commit got=%h exp=5a5a5a5a", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_range();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
